// File: rtl/dnn_aggr_ctrl.sv
// Sequencer for one hidden-layer pass: starts the compute stage, captures local ReLU
// outputs, waits (bounded) for two neighbour partials and emits registered aggregates.
module dnn_aggr_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_ready,
  input  logic [12:0]        y4_relu,
  input  logic [12:0]        y5_relu,
  input  logic [12:0]        y6_relu,
  input  logic [12:0]        y7_relu,
  input  logic               nb0_valid,
  input  logic [12:0]        nb0_y4,
  input  logic [12:0]        nb0_y5,
  input  logic [12:0]        nb0_y6,
  input  logic [12:0]        nb0_y7,
  input  logic               nb1_valid,
  input  logic [12:0]        nb1_y4,
  input  logic [12:0]        nb1_y5,
  input  logic [12:0]        nb1_y6,
  input  logic [12:0]        nb1_y7,
  output logic [2:0]         dnn_state,
  output logic signed [14:0] y4_n0_aggr,
  output logic signed [14:0] y5_n0_aggr,
  output logic signed [14:0] y6_n0_aggr,
  output logic signed [14:0] y7_n0_aggr,
  output logic signed [14:0] y4_n1_aggr,
  output logic signed [14:0] y5_n1_aggr,
  output logic signed [14:0] y6_n1_aggr,
  output logic signed [14:0] y7_n1_aggr,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAYER1    = 3'd1,
    CAPTURE   = 3'd2,
    WAIT_NB   = 3'd3,
    FINAL_OUT = 3'd4,
    DONE      = 3'd5
  } dnn_state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  dnn_state_t       state, state_nxt;
  logic [3:0][12:0] y_in, nb0_in, nb1_in;
  logic [3:0][12:0] loc_q, nb0_q, nb1_q, nb0_eff, nb1_eff;
  logic [3:0][14:0] n0_q, n1_q, n0_sum, n1_sum;
  logic             nb_open, nb0_take, nb1_take;
  logic             nb0_got, nb1_got, nb0_have, nb1_have;
  logic [7:0]       cnt, cnt_inc;
  logic             tmo_hit, start, enter_final, tmo_fire, timeout_q;

  assign y_in   = {y7_relu, y6_relu, y5_relu, y4_relu};
  assign nb0_in = {nb0_y7, nb0_y6, nb0_y5, nb0_y4};
  assign nb1_in = {nb1_y7, nb1_y6, nb1_y5, nb1_y4};

  assign nb_open  = (state == LAYER1) || (state == CAPTURE) || (state == WAIT_NB);
  assign nb0_take = nb_open && nb0_valid;
  assign nb1_take = nb_open && nb1_valid;
  // A strobe arriving on the deciding edge counts as already received.
  assign nb0_have = nb0_got || nb0_take;
  assign nb1_have = nb1_got || nb1_take;
  assign nb0_eff  = nb0_take ? nb0_in : (nb0_got ? nb0_q : '0);
  assign nb1_eff  = nb1_take ? nb1_in : (nb1_got ? nb1_q : '0);

  assign cnt_inc = cnt + 8'd1;
  assign tmo_hit = (cnt_inc == TMO);
  assign start   = (state == IDLE) && in_ready;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      n0_sum[k] = {2'b00, loc_q[k]} + {2'b00, nb0_eff[k]};
      n1_sum[k] = {2'b00, loc_q[k]} + {2'b00, nb1_eff[k]};
    end
  end

  always_comb begin
    state_nxt   = state;
    enter_final = 1'b0;
    tmo_fire    = 1'b0;
    case (state)
      IDLE:      if (in_ready) state_nxt = LAYER1;
      LAYER1:    state_nxt = CAPTURE;
      CAPTURE:   state_nxt = WAIT_NB;
      WAIT_NB: begin
        if (nb0_have && nb1_have) begin
          state_nxt   = FINAL_OUT;
          enter_final = 1'b1;
        end else if (tmo_hit) begin
          state_nxt   = FINAL_OUT;
          enter_final = 1'b1;
          tmo_fire    = 1'b1;
        end
      end
      FINAL_OUT: state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      nb0_got   <= 1'b0;
      nb1_got   <= 1'b0;
      loc_q     <= '0;
      nb0_q     <= '0;
      nb1_q     <= '0;
      n0_q      <= '0;
      n1_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= tmo_fire;
      if (start || state == CAPTURE) cnt <= '0;
      else if (state == WAIT_NB)     cnt <= cnt_inc;
      if (start) begin
        nb0_got <= 1'b0;
        nb1_got <= 1'b0;
      end else begin
        if (nb0_take) nb0_got <= 1'b1;
        if (nb1_take) nb1_got <= 1'b1;
      end
      if (nb0_take) nb0_q <= nb0_in;
      if (nb1_take) nb1_q <= nb1_in;
      if (state == CAPTURE) loc_q <= y_in;
      if (enter_final) begin
        n0_q <= n0_sum;
        n1_q <= n1_sum;
      end
    end
  end

  assign dnn_state   = state;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign timeout_err = timeout_q;

  assign y4_n0_aggr = $signed(n0_q[0]);
  assign y5_n0_aggr = $signed(n0_q[1]);
  assign y6_n0_aggr = $signed(n0_q[2]);
  assign y7_n0_aggr = $signed(n0_q[3]);
  assign y4_n1_aggr = $signed(n1_q[0]);
  assign y5_n1_aggr = $signed(n1_q[1]);
  assign y6_n1_aggr = $signed(n1_q[2]);
  assign y7_n1_aggr = $signed(n1_q[3]);

endmodule

// File: tb/tb_dnn_aggr_ctrl.sv
// Bench for dnn_aggr_ctrl: one instance at the default timeout and one at TIMEOUT_CYC=4,
// driven with the same stimulus and checked cycle by cycle against a timing/sum model.
module tb_dnn_aggr_ctrl;

  typedef logic [3:0][12:0] v13_t;
  typedef logic [3:0][14:0] v15_t;

  typedef struct {
    v13_t loc, d0, d0b, d1, d1b;
    int   a0, a0b, a1, a1b;
    int   fin_a, fin_b;
    bit   tmo_a, tmo_b;
    v15_t n0_a, n1_a, n0_b, n1_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_ready, nb0_valid, nb1_valid;
  v13_t y, nb0d, nb1d;
  logic [2:0] a_st, b_st;
  logic a_busy, a_done, a_tmo, b_busy, b_done, b_tmo;
  v15_t a_n0, a_n1, b_n0, b_n1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dnn_aggr_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .y4_relu(y[0]), .y5_relu(y[1]), .y6_relu(y[2]), .y7_relu(y[3]),
    .nb0_valid(nb0_valid), .nb0_y4(nb0d[0]), .nb0_y5(nb0d[1]), .nb0_y6(nb0d[2]), .nb0_y7(nb0d[3]),
    .nb1_valid(nb1_valid), .nb1_y4(nb1d[0]), .nb1_y5(nb1d[1]), .nb1_y6(nb1d[2]), .nb1_y7(nb1d[3]),
    .dnn_state(a_st),
    .y4_n0_aggr(a_n0[0]), .y5_n0_aggr(a_n0[1]), .y6_n0_aggr(a_n0[2]), .y7_n0_aggr(a_n0[3]),
    .y4_n1_aggr(a_n1[0]), .y5_n1_aggr(a_n1[1]), .y6_n1_aggr(a_n1[2]), .y7_n1_aggr(a_n1[3]),
    .busy(a_busy), .done(a_done), .timeout_err(a_tmo)
  );

  dnn_aggr_ctrl #(.TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .y4_relu(y[0]), .y5_relu(y[1]), .y6_relu(y[2]), .y7_relu(y[3]),
    .nb0_valid(nb0_valid), .nb0_y4(nb0d[0]), .nb0_y5(nb0d[1]), .nb0_y6(nb0d[2]), .nb0_y7(nb0d[3]),
    .nb1_valid(nb1_valid), .nb1_y4(nb1d[0]), .nb1_y5(nb1d[1]), .nb1_y6(nb1d[2]), .nb1_y7(nb1d[3]),
    .dnn_state(b_st),
    .y4_n0_aggr(b_n0[0]), .y5_n0_aggr(b_n0[1]), .y6_n0_aggr(b_n0[2]), .y7_n0_aggr(b_n0[3]),
    .y4_n1_aggr(b_n1[0]), .y5_n1_aggr(b_n1[1]), .y6_n1_aggr(b_n1[2]), .y7_n1_aggr(b_n1[3]),
    .busy(b_busy), .done(b_done), .timeout_err(b_tmo)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic v13_t v4(input int a, input int b, input int c, input int d);
    return {13'(d), 13'(c), 13'(b), 13'(a)};
  endfunction

  function automatic v15_t e4(input int a, input int b, input int c, input int d);
    return {15'(d), 15'(c), 15'(b), 15'(a)};
  endfunction

  function automatic v13_t rnd4();
    v13_t r;
    for (int k = 0; k < 4; k++) r[k] = 13'($urandom_range(0, 4095));
    return r;
  endfunction

  function automatic logic [5:0] stat(input int i);
    return (i == 0) ? {a_st, a_busy, a_done, a_tmo} : {b_st, b_busy, b_done, b_tmo};
  endfunction

  function automatic logic [119:0] aggr(input int i);
    return (i == 0) ? {a_n1, a_n0} : {b_n1, b_n0};
  endfunction

  // Cycle 0 is the IDLE cycle with in_ready high; fin is the FINAL_OUT cycle.
  function automatic logic [5:0] exp_stat(input int c, input int fin, input bit tmo);
    logic [2:0] s;
    if (c <= 0)           s = 3'd0;
    else if (c < 3)       s = 3'(c);
    else if (c < fin)     s = 3'd3;
    else if (c == fin)    s = 3'd4;
    else if (c == fin + 1) s = 3'd5;
    else                  s = 3'd0;
    return {s, (s != 3'd0), (c == fin + 1), (tmo && c == fin)};
  endfunction

  function automatic int earliest(input int a, input int b);
    int e = -1;
    if (a >= 1) e = a;
    if (b >= 1 && (e < 0 || b < e)) e = b;
    return e;
  endfunction

  function automatic v13_t latest(input int fin, input int a, input v13_t d, input int b, input v13_t db);
    v13_t r = '0;
    int best = -1;
    if (a >= 1 && a < fin && a > best) begin best = a; r = d; end
    if (b >= 1 && b < fin && b > best) begin best = b; r = db; end
    return r;
  endfunction

  // Strobes count from LAYER1 onward; both present by the last WAIT_NB cycle wins, else timeout.
  task automatic model(input int tc, input vec_t v, output int fin, output bit tmo,
                       output v15_t n0, output v15_t n1);
    int e0 = earliest(v.a0, v.a0b);
    int e1 = earliest(v.a1, v.a1b);
    int m = (e0 > e1) ? e0 : e1;
    int w_end = 2 + tc;
    v13_t g0, g1;
    if (e0 > 0 && e1 > 0 && m <= w_end) begin
      fin = ((m < 3) ? 3 : m) + 1;
      tmo = 1'b0;
    end else begin
      fin = w_end + 1;
      tmo = 1'b1;
    end
    g0 = latest(fin, v.a0, v.d0, v.a0b, v.d0b);
    g1 = latest(fin, v.a1, v.d1, v.a1b, v.d1b);
    for (int k = 0; k < 4; k++) begin
      n0[k] = 15'(v.loc[k]) + 15'(g0[k]);
      n1[k] = 15'(v.loc[k]) + 15'(g1[k]);
    end
  endtask

  function automatic vec_t mk(input v13_t loc, input int a0, input v13_t d0, input int a0b, input v13_t d0b,
                              input int a1, input v13_t d1, input int a1b, input v13_t d1b,
                              input int fa, input bit ta, input v15_t n0a, input v15_t n1a,
                              input int fb, input bit tb, input v15_t n0b, input v15_t n1b);
    vec_t v;
    v.loc = loc; v.a0 = a0; v.d0 = d0; v.a0b = a0b; v.d0b = d0b;
    v.a1 = a1; v.d1 = d1; v.a1b = a1b; v.d1b = d1b;
    v.fin_a = fa; v.tmo_a = ta; v.n0_a = n0a; v.n1_a = n1a;
    v.fin_b = fb; v.tmo_b = tb; v.n0_b = n0b; v.n1_b = n1b;
    return v;
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_seq(input vec_t v, input string tag);
    int last = ((v.fin_a > v.fin_b) ? v.fin_a : v.fin_b) + 2;
    for (int c = 0; c <= last; c++) begin
      in_ready  = (c == 0);
      y         = (c == 2) ? v.loc : rnd4();
      nb0_valid = (c == v.a0) || (c == v.a0b);
      nb0d      = (c == v.a0b) ? v.d0b : (c == v.a0) ? v.d0 : rnd4();
      nb1_valid = (c == v.a1) || (c == v.a1b);
      nb1d      = (c == v.a1b) ? v.d1b : (c == v.a1) ? v.d1 : rnd4();
      @(negedge clk);
      chk($sformatf("%s a state c%0d", tag, c), 128'(stat(0)), 128'(exp_stat(c, v.fin_a, v.tmo_a)));
      chk($sformatf("%s b state c%0d", tag, c), 128'(stat(1)), 128'(exp_stat(c, v.fin_b, v.tmo_b)));
      if (c == v.fin_a || c == last)
        chk($sformatf("%s a aggr c%0d", tag, c), 128'(aggr(0)), 128'({v.n1_a, v.n0_a}));
      if (c == v.fin_b || c == last)
        chk($sformatf("%s b aggr c%0d", tag, c), 128'(aggr(1)), 128'({v.n1_b, v.n0_b}));
      @(posedge clk);
      #1;
    end
    in_ready = 1'b0; nb0_valid = 1'b0; nb1_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t tab[7];
    vec_t v;
    v13_t l1, z;
    v15_t n0, n1, n0b, n1b;
    int fa, fb, c_end;
    bit ta, tb;

    z  = '0;
    l1 = v4(10, 20, 30, 40);
    tab[0] = mk(l1, 2, v4(1,2,3,4), -1, z, 2, v4(100,0,0,5), -1, z,
                4, 0, e4(11,22,33,44), e4(110,20,30,45), 4, 0, e4(11,22,33,44), e4(110,20,30,45));
    tab[1] = mk(l1, 2, v4(1,2,3,4), -1, z, 10, v4(7,7,7,7), -1, z,
                11, 0, e4(11,22,33,44), e4(17,27,37,47), 7, 1, e4(11,22,33,44), e4(10,20,30,40));
    tab[2] = mk(l1, 1, v4(1,2,3,4), -1, z, -1, z, -1, z,
                258, 1, e4(11,22,33,44), e4(10,20,30,40), 7, 1, e4(11,22,33,44), e4(10,20,30,40));
    tab[3] = mk(v4(4095,4095,4095,4095), 2, v4(4095,4095,4095,4095), -1, z, 1, v4(4095,4095,4095,4095), -1, z,
                4, 0, e4(8190,8190,8190,8190), e4(8190,8190,8190,8190),
                4, 0, e4(8190,8190,8190,8190), e4(8190,8190,8190,8190));
    tab[4] = mk(l1, 1, v4(1,1,1,1), 3, v4(2,2,2,2), 6, v4(5,5,5,5), -1, z,
                7, 0, e4(12,22,32,42), e4(15,25,35,45), 7, 0, e4(12,22,32,42), e4(15,25,35,45));
    tab[5] = mk(l1, 0, v4(9,9,9,9), -1, z, 2, v4(1,1,1,1), -1, z,
                258, 1, e4(10,20,30,40), e4(11,21,31,41), 7, 1, e4(10,20,30,40), e4(11,21,31,41));
    tab[6] = mk(l1, 2, v4(1,2,3,4), 4, v4(50,50,50,50), 2, v4(100,0,0,5), 5, v4(60,60,60,60),
                4, 0, e4(11,22,33,44), e4(110,20,30,45), 4, 0, e4(11,22,33,44), e4(110,20,30,45));

    rst_n = 1'b0; in_ready = 1'b0; nb0_valid = 1'b0; nb1_valid = 1'b0;
    y = '0; nb0d = '0; nb1d = '0;
    repeat (2) begin
      @(negedge clk);
      chk("reset a state", 128'(stat(0)), 128'(0));
      chk("reset b state", 128'(stat(1)), 128'(0));
      chk("reset a aggr", 128'(aggr(0)), 128'(0));
      chk("reset b aggr", 128'(aggr(1)), 128'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_seq(tab[i], $sformatf("vec%0d", i));

    // in_ready held high: two runs with one IDLE cycle between; strobes in DONE are dropped.
    c_end = 6 + 258 + 2;
    for (int c = 0; c <= c_end; c++) begin
      in_ready  = (c <= 12);
      y         = (c == 2) ? l1 : (c == 8) ? v4(100,100,100,100) : rnd4();
      nb0_valid = (c == 2) || (c == 5) || (c == 8);
      nb0d      = (c == 2) ? v4(1,1,1,1) : (c == 8) ? v4(2,2,2,2) : v4(3,3,3,3);
      nb1_valid = (c == 2) || (c == 5);
      nb1d      = (c == 2) ? v4(1,1,1,1) : v4(3,3,3,3);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        fb = (i == 0) ? 258 : 7;
        chk($sformatf("held %0d state c%0d", i, c), 128'(stat(i)),
            128'((c < 6) ? exp_stat(c, 4, 1'b0) : exp_stat(c - 6, fb, 1'b1)));
        if (c == 4)
          chk($sformatf("held %0d aggr1", i), 128'(aggr(i)), 128'({e4(11,21,31,41), e4(11,21,31,41)}));
        if (c == 6 + fb)
          chk($sformatf("held %0d aggr2", i), 128'(aggr(i)), 128'({e4(100,100,100,100), e4(102,102,102,102)}));
      end
      @(posedge clk); #1;
    end
    in_ready = 1'b0; nb0_valid = 1'b0; nb1_valid = 1'b0;

    // Reset while waiting for neighbours.
    for (int c = 0; c < 5; c++) begin
      in_ready = (c == 0);
      @(posedge clk); #1;
    end
    in_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset a state", 128'(stat(0)), 128'(0));
    chk("midreset b state", 128'(stat(1)), 128'(0));
    chk("midreset a aggr", 128'(aggr(0)), 128'(0));
    chk("midreset b aggr", 128'(aggr(1)), 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("inreset a", 128'(stat(0)), 128'(0));
      chk("inreset b", 128'(stat(1)), 128'(0));
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postreset a", 128'(stat(0)), 128'(0));
      chk("postreset b", 128'(stat(1)), 128'(0));
    end
    @(posedge clk); #1;
    run_seq(tab[0], "restart");

    for (int n = 0; n < 40; n++) begin
      int r;
      v.loc = rnd4(); v.d0 = rnd4(); v.d0b = rnd4(); v.d1 = rnd4(); v.d1b = rnd4();
      r = $urandom_range(0, 99);
      v.a0 = (r < 8) ? -1 : (r < 18) ? $urandom_range(7, 14) : $urandom_range(0, 6);
      r = $urandom_range(0, 99);
      v.a1 = (r < 8) ? -1 : (r < 18) ? $urandom_range(7, 14) : $urandom_range(0, 6);
      v.a0b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
      v.a1b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
      if (v.a0b == v.a0) v.a0b = -1;
      if (v.a1b == v.a1) v.a1b = -1;
      model(255, v, fa, ta, n0, n1);
      model(4, v, fb, tb, n0b, n1b);
      v.fin_a = fa; v.tmo_a = ta; v.n0_a = n0; v.n1_a = n1;
      v.fin_b = fb; v.tmo_b = tb; v.n0_b = n0b; v.n1_b = n1b;
      run_seq(v, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
